// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered CH-to-1 mux with direct select or round-robin scan, valid/ready output.
// Define MUX_CH_MASK_EN to add the ch_mask input (per-channel enable for scan and direct select).
module mux_scan_nx1 #(
    parameter int CH   = 16,
    parameter int W    = 8,
    parameter int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [CH*W-1:0] d,
`ifdef MUX_CH_MASK_EN
    input  logic [CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]    y,
    output logic [SELW-1:0] y_ch,
    output logic            y_valid,
    input  logic            y_ready,
    output logic            err,
    output logic            wrap
);
    logic [W-1:0]    ch [CH];
    logic [CH-1:0]   mask;
    logic [W-1:0]    y_q, y_d;
    logic [SELW-1:0] y_ch_q, y_ch_d, ptr_q, ptr_d;
    logic            y_valid_q, y_valid_d, err_q, err_d, wrap_q, wrap_d;
    logic [SELW-1:0] cur, nxt, top;
    logic            any_en, sel_ok, load;

`ifdef MUX_CH_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign ch[g] = d[g*W +: W];
    end

    function automatic logic [SELW-1:0] ring_add(input logic [SELW-1:0] a, input int k);
        return SELW'((int'(a) + k) % CH);
    endfunction

    // cur: first enabled channel at or after ptr; nxt: first enabled channel after cur.
    always_comb begin
        cur    = ptr_q;
        nxt    = ptr_q;
        top    = '0;
        any_en = 1'b0;
        for (int i = 0; i < CH; i++)
            if (mask[SELW'(i)]) begin
                top    = SELW'(i);
                any_en = 1'b1;
            end
        for (int k = CH - 1; k >= 0; k--)
            if (mask[ring_add(ptr_q, k)]) cur = ring_add(ptr_q, k);
        for (int k = CH; k >= 1; k--)
            if (mask[ring_add(cur, k)]) nxt = ring_add(cur, k);
    end

    assign sel_ok = (int'(sel) < CH) && mask[sel];
    assign load   = en && (!y_valid_q || y_ready) && (!mode || any_en);

    always_comb begin
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        err_d     = err_q;
        ptr_d     = ptr_q;
        y_valid_d = y_valid_q && !y_ready;
        wrap_d    = 1'b0;
        if (load) begin
            y_valid_d = 1'b1;
            y_d       = mode ? ch[cur] : (sel_ok ? ch[sel] : '0);
            y_ch_d    = mode ? cur : sel;
            err_d     = !mode && !sel_ok;
            ptr_d     = mode ? nxt : ptr_q;
            wrap_d    = mode && (cur == top);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign err     = err_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: directed and random stimulus against a channel-level reference model (CH=12).
module tb_mux_scan_nx1;
    localparam int CH = 12;
    localparam int W  = 8;
    localparam int SELW = $clog2(CH);

    logic            clk = 1'b0;
    logic            rst_n, en, mode, y_ready;
    logic [SELW-1:0] sel;
    logic [W-1:0]    dv [CH];
    logic [CH*W-1:0] d;
    logic [CH-1:0]   ch_mask;
    logic [W-1:0]    y;
    logic [SELW-1:0] y_ch;
    logic            y_valid, err, wrap;

    int checks = 0;
    int errors = 0;

    int       m_ptr, m_ch;
    logic     m_valid, m_err, m_wrap;
    logic [W-1:0] m_y;

    always #5 clk = ~clk;

    always_comb begin
        d = '0;
        for (int i = 0; i < CH; i++) d[i*W +: W] = dv[i];
    end

    mux_scan_nx1 #(.CH(CH), .W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .d(d),
`ifdef MUX_CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .y(y), .y_ch(y_ch), .y_valid(y_valid), .y_ready(y_ready), .err(err), .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one accepted sample per load, scanning enabled channels in circular order.
    task automatic model();
        int c, hi, any;
        bit ld;
        if (!rst_n) begin
            m_ptr = 0; m_ch = 0; m_valid = 0; m_err = 0; m_wrap = 0; m_y = '0;
            return;
        end
        any = 0; hi = 0;
        for (int i = 0; i < CH; i++) if (ch_mask[i]) begin any = 1; hi = i; end
        ld = en && (!m_valid || y_ready) && (!mode || any != 0);
        m_wrap = 0;
        if (ld) begin
            m_valid = 1;
            if (mode) begin
                c = m_ptr;
                while (!ch_mask[c]) c = (c + 1) % CH;
                m_y = dv[c]; m_ch = c; m_err = 0; m_wrap = (c == hi);
                m_ptr = (c + 1) % CH;
                while (!ch_mask[m_ptr]) m_ptr = (m_ptr + 1) % CH;
            end else begin
                m_ch = int'(sel);
                if (m_ch < CH && ch_mask[m_ch]) begin m_y = dv[m_ch]; m_err = 0; end
                else begin m_y = '0; m_err = 1; end
            end
        end else if (m_valid && y_ready) m_valid = 0;
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        chk("valid", 32'(y_valid), 32'(m_valid));
        chk("y", 32'(y), 32'(m_y));
        chk("y_ch", 32'(y_ch), m_ch);
        chk("err", 32'(err), 32'(m_err));
        chk("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; y_ready = 1'b1; sel = '0; ch_mask = '1;
        for (int i = 0; i < CH; i++) dv[i] = W'(8'h10 + i);
        do_reset();
        chk("rst_valid", 32'(y_valid), 0);
        chk("rst_y", 32'(y), 0);
        // direct select
        en = 1'b1; sel = 4'd5;
        step();
        chk("t1_y", 32'(y), 32'h15);
        chk("t1_ch", 32'(y_ch), 5);
        chk("t1_valid", 32'(y_valid), 1);
        chk("t1_err", 32'(err), 0);
        // full scan with wrap
        mode = 1'b1;
        for (int k = 0; k <= CH; k++) begin
            step();
            chk("t2_ch", 32'(y_ch), k % CH);
            chk("t2_wrap", 32'(wrap), 32'(k == CH - 1));
            chk("t2_y", 32'(y), 32'h10 + (k % CH));
        end
        // backpressure at channel 3
        do_reset();
        for (int k = 0; k < 4; k++) step();
        y_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dv[3] = W'($urandom);
            step();
            chk("t3_ch", 32'(y_ch), 3);
            chk("t3_y", 32'(y), 32'h13);
        end
        y_ready = 1'b1;
        step();
        chk("t3_next", 32'(y_ch), 4);
        // en=0 with a held sample
        en = 1'b0; y_ready = 1'b0;
        step();
        chk("hold_valid", 32'(y_valid), 1);
        y_ready = 1'b1;
        step();
        chk("drain_valid", 32'(y_valid), 0);
        // out-of-range direct select
        en = 1'b1; mode = 1'b0; sel = 4'd13;
        step();
        chk("t4_y", 32'(y), 0);
        chk("t4_ch", 32'(y_ch), 13);
        chk("t4_err", 32'(err), 1);
        sel = 4'd2;
        step();
        chk("t4_err2", 32'(err), 0);
        // reset mid-scan, resume at channel 0
        mode = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) step();
        chk("t5_at7", 32'(y_ch), 7);
        do_reset();
        chk("t5_valid", 32'(y_valid), 0);
        chk("t5_y", 32'(y), 0);
        step();
        chk("t5_ch", 32'(y_ch), 0);
`ifdef MUX_CH_MASK_EN
        do_reset();
        ch_mask = 12'h0A5;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_ch", 32'(y_ch), (k == 0 || k == 4) ? 0 : (k == 1 ? 2 : (k == 2 ? 5 : 7)));
            chk("t6_wrap", 32'(wrap), 32'(k == 3));
        end
        ch_mask = '0;
        step();
        chk("t6_drop", 32'(y_valid), 0);
        ch_mask = 12'h0A5; mode = 1'b0; sel = 4'd1;
        step();
        chk("t6_masked_err", 32'(err), 1);
`endif
        // random phase
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 60) != 0);
            en      = ($urandom_range(0, 4) != 0);
            mode    = ($urandom_range(0, 2) != 0);
            y_ready = ($urandom_range(0, 3) != 0);
            sel     = SELW'($urandom_range(0, 15));
            for (int i = 0; i < CH; i++) dv[i] = W'($urandom);
`ifdef MUX_CH_MASK_EN
            if ($urandom_range(0, 9) == 0) ch_mask = ($urandom_range(0, 3) == 0) ? '0 : CH'($urandom);
`endif
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
